// File: rtl/sn74ls443_seq.sv
// Transfer sequencer for an sn74ls443 tridirectional buffer: queues (src, dst) requests and
// steps each through SETUP -> DRIVE -> TURN with registered, glitch-free control pins.
module sn74ls443_seq #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DRIVE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [2:0] req_dst,
  output logic       cs,
  output logic       s1,
  output logic       s0,
  output logic       ga,
  output logic       gb,
  output logic       gc,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned DrvW = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSetup = 2'd1;
  localparam logic [1:0] StDrive = 2'd2;
  localparam logic [1:0] StTurn  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [DrvW-1:0] drv_cnt_q, drv_cnt_d;
  logic [1:0]      cur_src_q, cur_src_d;
  logic [2:0]      cur_dst_q, cur_dst_d;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [4:0]      mem_q [DEPTH];

  logic       cs_q, cs_d;
  logic [1:0] s_q, s_d;
  logic [2:0] g_q, g_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [2:0] own_bit;
  logic       req_invalid;
  logic       accept;
  logic       push;
  logic       pop;
  logic       q_empty;

  // Source port's own enable bit in the {A,B,C} mask.
  assign own_bit     = 3'b100 >> req_src;
  assign req_invalid = (req_src == 2'b11) | (req_dst == 3'b000) | (|(req_dst & own_bit));
  assign req_ready   = (count_q != CntW'(DEPTH));
  assign accept      = req_valid & req_ready;
  assign push        = accept & ~req_invalid;
  assign q_empty     = (count_q == '0);

  always_comb begin
    state_d   = state_q;
    drv_cnt_d = drv_cnt_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d   = StDrive;
        drv_cnt_d = DrvW'(DRIVE_CYCLES - 1);
      end
      StDrive: begin
        if (drv_cnt_q == '0) begin
          state_d = StTurn;
        end else begin
          drv_cnt_d = drv_cnt_q - 1'b1;
        end
      end
      StTurn: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      {cur_src_d, cur_dst_d} = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pins are decoded from the next state so they only ever change on the clock edge.
  always_comb begin
    cs_d   = (state_d == StIdle);
    s_d    = (state_d == StIdle) ? 2'b11 : cur_src_d;
    g_d    = (state_d == StDrive) ? ~cur_dst_d : 3'b111;
    done_d = (state_d == StTurn);
    err_d  = accept & req_invalid;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= StIdle;
      drv_cnt_q <= '0;
      cur_src_q <= 2'b11;
      cur_dst_q <= 3'b000;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cs_q      <= 1'b1;
      s_q       <= 2'b11;
      g_q       <= 3'b111;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      drv_cnt_q <= drv_cnt_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cs_q      <= cs_d;
      s_q       <= s_d;
      g_q       <= g_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_src, req_dst};
    end
  end

  assign cs       = cs_q;
  assign {s1, s0} = s_q;
  assign {ga, gb, gc} = g_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != StIdle) | ~q_empty;

endmodule

// File: tb/tb_sn74ls443_seq.sv
// Directed bench for sn74ls443_seq: cycle-exact pin sequences, rejection, full queue, reset.
module tb_sn74ls443_seq;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_src = 2'b00;
  logic [2:0] req_dst = 3'b000;
  logic       req_ready, cs, s1, s0, ga, gb, gc, busy, done, err;

  int total = 0;
  int bad   = 0;

  sn74ls443_seq #(
    .DEPTH        (4),
    .DRIVE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .cs        (cs),
    .s1        (s1),
    .s0        (s0),
    .ga        (ga),
    .gb        (gb),
    .gc        (gc),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [1:0] s;
  logic [2:0] g;
  logic [2:0] own_s;
  assign s     = {s1, s0};
  assign g     = {ga, gb, gc};
  assign own_s = 3'b100 >> s;

  // Pin monitor: logs each DRIVE pattern with its length, counts done pulses and unsafe states.
  int         safety_viol = 0;
  int         done_cnt = 0;
  int         drv_n = 0;
  logic [2:0] drv_g [32];
  int         drv_len [32];
  logic       in_drv = 1'b0;
  logic [2:0] last_g = 3'b111;

  always @(negedge clk) begin
    if (!clr_n) begin
      in_drv <= 1'b0;
    end else begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (g !== 3'b111 && (cs !== 1'b0 || s == 2'b11 || (~g & own_s) != 3'b000)) begin
        safety_viol <= safety_viol + 1;
      end
      if (g !== 3'b111) begin
        if ((!in_drv || g != last_g) && drv_n < 32) begin
          drv_g[drv_n]   <= g;
          drv_len[drv_n] <= 1;
          drv_n          <= drv_n + 1;
        end else if (in_drv && drv_n > 0) begin
          drv_len[drv_n-1] <= drv_len[drv_n-1] + 1;
        end
        in_drv <= 1'b1;
        last_g <= g;
      end else begin
        in_drv <= 1'b0;
      end
    end
  end

  // {cs, s1, s0, ga, gb, gc, done, err, busy, req_ready}
  function automatic logic [9:0] snap();
    return {cs, s1, s0, ga, gb, gc, done, err, busy, req_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 clr_n = 1'b0;
    #2;
    total++;
    if (snap() !== 10'b1_11_111_0_0_0_1) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", snap(), 10'b1_11_111_0_0_0_1);
    end
    step();
    @(negedge clk);
    clr_n = 1'b1;
    step();
    total++;
    if (snap() !== 10'b1_11_111_0_0_0_1) begin
      bad++;
      $display("FAIL reset_release_idle: got %b want %b", snap(), 10'b1_11_111_0_0_0_1);
    end
  endtask

  task automatic test_single();
    logic [9:0] exp_t [5];
    int         base_d;
    base_d = done_cnt;
    exp_t[0] = 10'b0_00_111_0_0_1_1;
    exp_t[1] = 10'b0_00_100_0_0_1_1;
    exp_t[2] = 10'b0_00_100_0_0_1_1;
    exp_t[3] = 10'b0_00_111_1_0_1_1;
    exp_t[4] = 10'b1_11_111_0_0_0_1;
    req_valid = 1'b1;
    req_src   = 2'b00;
    req_dst   = 3'b011;
    step();
    req_valid = 1'b0;
    total++;
    if (snap() !== 10'b1_11_111_0_0_1_1) begin
      bad++;
      $display("FAIL single_e0: got %b want %b", snap(), 10'b1_11_111_0_0_1_1);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (snap() !== exp_t[k]) begin
        bad++;
        $display("FAIL single_e%0d: got %b want %b", k + 1, snap(), exp_t[k]);
      end
    end
    total++;
    if (done_cnt - base_d !== 1) begin
      bad++;
      $display("FAIL single_done_count: got %0d want 1", done_cnt - base_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_t [13];
    int         base_d;
    base_d = done_cnt;
    exp_t[0]  = 10'b0_01_111_0_0_1_1;
    exp_t[1]  = 10'b0_01_110_0_0_1_1;
    exp_t[2]  = 10'b0_01_110_0_0_1_1;
    exp_t[3]  = 10'b0_01_111_1_0_1_1;
    exp_t[4]  = 10'b0_10_111_0_0_1_1;
    exp_t[5]  = 10'b0_10_011_0_0_1_1;
    exp_t[6]  = 10'b0_10_011_0_0_1_1;
    exp_t[7]  = 10'b0_10_111_1_0_1_1;
    exp_t[8]  = 10'b0_00_111_0_0_1_1;
    exp_t[9]  = 10'b0_00_101_0_0_1_1;
    exp_t[10] = 10'b0_00_101_0_0_1_1;
    exp_t[11] = 10'b0_00_111_1_0_1_1;
    exp_t[12] = 10'b1_11_111_0_0_0_1;
    req_valid = 1'b1;
    req_src   = 2'b01;
    req_dst   = 3'b001;
    step();
    for (int k = 0; k < 13; k++) begin
      if (k == 0) begin
        req_src = 2'b10;
        req_dst = 3'b100;
      end else if (k == 1) begin
        req_src = 2'b00;
        req_dst = 3'b010;
      end else begin
        req_valid = 1'b0;
      end
      step();
      total++;
      if (snap() !== exp_t[k]) begin
        bad++;
        $display("FAIL b2b_e%0d: got %b want %b", k + 1, snap(), exp_t[k]);
      end
    end
    total++;
    if (done_cnt - base_d !== 3) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d want 3", done_cnt - base_d);
    end
  endtask

  task automatic test_invalid();
    logic [1:0] src_t [3];
    logic [2:0] dst_t [3];
    src_t[0] = 2'b11; dst_t[0] = 3'b011;
    src_t[1] = 2'b00; dst_t[1] = 3'b000;
    src_t[2] = 2'b01; dst_t[2] = 3'b010;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_src   = src_t[k];
      req_dst   = dst_t[k];
      step();
      req_valid = 1'b0;
      total++;
      if (snap() !== 10'b1_11_111_0_1_0_1) begin
        bad++;
        $display("FAIL invalid%0d_err: got %b want %b", k, snap(), 10'b1_11_111_0_1_0_1);
      end
      step();
      total++;
      if (snap() !== 10'b1_11_111_0_0_0_1) begin
        bad++;
        $display("FAIL invalid%0d_after: got %b want %b", k, snap(), 10'b1_11_111_0_0_0_1);
      end
    end
  endtask

  task automatic test_full();
    logic [1:0] src_t [6];
    logic [2:0] dst_t [6];
    logic [2:0] gexp_t [6];
    int         base_n;
    int         base_d;
    int         waited;
    base_n = drv_n;
    base_d = done_cnt;
    src_t[0] = 2'b00; dst_t[0] = 3'b001; gexp_t[0] = 3'b110;
    src_t[1] = 2'b01; dst_t[1] = 3'b100; gexp_t[1] = 3'b011;
    src_t[2] = 2'b10; dst_t[2] = 3'b010; gexp_t[2] = 3'b101;
    src_t[3] = 2'b00; dst_t[3] = 3'b011; gexp_t[3] = 3'b100;
    src_t[4] = 2'b01; dst_t[4] = 3'b101; gexp_t[4] = 3'b010;
    src_t[5] = 2'b10; dst_t[5] = 3'b110; gexp_t[5] = 3'b001;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_src   = src_t[k];
      req_dst   = dst_t[k];
      step();
    end
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready_low: got %b want 0", req_ready);
    end
    req_src = src_t[5];
    req_dst = dst_t[5];
    step();
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_ready_after_pop: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_fifth_accepted: ready got %b want 0", req_ready);
    end
    waited = 0;
    while (busy !== 1'b0 && waited < 200) begin
      step();
      waited++;
    end
    total++;
    if (waited >= 200) begin
      bad++;
      $display("FAIL full_drain_timeout: busy got %b want 0", busy);
    end
    total++;
    if (done_cnt - base_d !== 6) begin
      bad++;
      $display("FAIL full_done_count: got %0d want 6", done_cnt - base_d);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (drv_g[base_n+k] !== gexp_t[k] || drv_len[base_n+k] !== 2) begin
        bad++;
        $display("FAIL full_order%0d: got g=%b len=%0d want g=%b len=2", k, drv_g[base_n+k],
                 drv_len[base_n+k], gexp_t[k]);
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    req_valid = 1'b1;
    req_src   = 2'b00;
    req_dst   = 3'b010;
    step();
    req_src   = 2'b10;
    req_dst   = 3'b100;
    step();
    req_valid = 1'b0;
    step();
    total++;
    if (snap() !== 10'b0_00_101_0_0_1_1) begin
      bad++;
      $display("FAIL rst_mid_drive_pre: got %b want %b", snap(), 10'b0_00_101_0_0_1_1);
    end
    #2 clr_n = 1'b0;
    #1;
    total++;
    if (snap() !== 10'b1_11_111_0_0_0_1) begin
      bad++;
      $display("FAIL rst_mid_drive_async: got %b want %b", snap(), 10'b1_11_111_0_0_0_1);
    end
    #2 clr_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (snap() !== 10'b1_11_111_0_0_0_1) begin
        bad++;
        $display("FAIL rst_mid_drive_after%0d: got %b want %b", k, snap(),
                 10'b1_11_111_0_0_0_1);
      end
    end
  endtask

  task automatic test_safety();
    total++;
    if (safety_viol !== 0) begin
      bad++;
      $display("FAIL safety: got %0d violations want 0", safety_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_full();
    test_reset_mid_drive();
    test_safety();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
